// File: rtl/serial_add.sv
// serial_add: bit-serial LSB-first adder with valid/ready handshakes on both sides
// Ports: clk_i, reset_i (sync, active-high); operand side valid_i/ready_o/a_i/b_i;
// result side valid_o/ready_i/sum_o/carry_o, held stable in DONE until accepted.
module half_add (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_add #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [width_p-1:0] a_i,
    input  logic [width_p-1:0] b_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [width_p-1:0] sum_o,
    output logic               carry_o
);
    localparam int cw = $clog2(width_p + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t             state, state_n;
    logic [width_p-1:0] a_r, b_r, res_r;
    logic [cw-1:0]      cnt;
    logic               carry_r, s1, c1, sbit, c2;
    half_add ha1 (.a(a_r[0]), .b(b_r[0]), .s(s1), .c(c1));
    half_add ha2 (.a(s1), .b(carry_r), .s(sbit), .c(c2));
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = valid_i ? BUSY : IDLE;
            BUSY:    state_n = (cnt == cw'(width_p - 1)) ? DONE : BUSY;
            DONE:    state_n = ready_i ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            res_r   <= '0;
            carry_r <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && valid_i) begin
                a_r     <= a_i;
                b_r     <= b_i;
                carry_r <= 1'b0;
                cnt     <= '0;
            end else if (state == BUSY) begin
                a_r     <= a_r >> 1;
                b_r     <= b_r >> 1;
                // sum bit enters at the MSB; the extra top bit keeps width_p=1 legal
                res_r   <= width_p'({sbit, res_r} >> 1);
                carry_r <= c1 | c2;
                cnt     <= cnt + cw'(1);
            end
        end
    end
    assign ready_o = state == IDLE;
    assign valid_o = state == DONE;
    assign sum_o   = res_r;
    assign carry_o = carry_r;
endmodule

// File: tb/tb_serial_add.sv
// tb_serial_add: scoreboard bench for serial_add at widths 8, 1 and 3
module tb_serial_add;
    logic clk = 1'b0, rst = 1'b1;
    int   cyc = 0, nchk = 0, nerr = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       v8 = 1'b0, r8 = 1'b0, rdy8, vo8, co8;
    logic [7:0] a8 = '0, b8 = '0, s8;
    logic [8:0] q8[$];

    logic       ex_v[2], ex_r[2], ex_rdy[2], ex_vo[2];
    logic [2:0] ex_a[2], ex_b[2];
    logic [3:0] ex_cs[2];
    logic       rdy1, vo1, co1, rdy3, vo3, co3;
    logic [0:0] s1;
    logic [2:0] s3;
    assign ex_rdy[0] = rdy1;
    assign ex_rdy[1] = rdy3;
    assign ex_vo[0]  = vo1;
    assign ex_vo[1]  = vo3;
    assign ex_cs[0]  = {2'b0, co1, s1};
    assign ex_cs[1]  = {co3, s3};

    serial_add #(.width_p(8)) dut8 (
        .clk_i(clk), .reset_i(rst), .valid_i(v8), .ready_o(rdy8), .a_i(a8), .b_i(b8),
        .valid_o(vo8), .ready_i(r8), .sum_o(s8), .carry_o(co8)
    );
    serial_add #(.width_p(1)) dut1 (
        .clk_i(clk), .reset_i(rst), .valid_i(ex_v[0]), .ready_o(rdy1), .a_i(ex_a[0][0:0]),
        .b_i(ex_b[0][0:0]), .valid_o(vo1), .ready_i(ex_r[0]), .sum_o(s1), .carry_o(co1)
    );
    serial_add #(.width_p(3)) dut3 (
        .clk_i(clk), .reset_i(rst), .valid_i(ex_v[1]), .ready_o(rdy3), .a_i(ex_a[1]),
        .b_i(ex_b[1]), .valid_o(vo3), .ready_i(ex_r[1]), .sum_o(s3), .carry_o(co3)
    );

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input int hold, input bit noise);
        int lat;
        logic [8:0] exp, got;
        @(negedge clk);
        nchk++;
        if (rdy8 !== 1'b1) begin nerr++; $display("FAIL accept_ready: ready_o=%b want 1", rdy8); end
        a8 = a; b8 = b; v8 = 1'b1; r8 = 1'b0;
        q8.push_back({1'b0, a} + {1'b0, b});
        @(negedge clk);
        v8 = 1'b0;
        lat = 0;
        while (vo8 !== 1'b1 && lat < 40) begin
            nchk++;
            if (rdy8 !== 1'b0) begin nerr++; $display("FAIL busy_ready: ready_o=%b want 0 at lat %0d", rdy8, lat); end
            if (noise) begin
                v8 = (lat % 2) == 0;
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        nchk++;
        if (lat != 8) begin nerr++; $display("FAIL latency: got %0d cycles want 8", lat); end
        exp = q8.pop_front();
        got = {co8, s8};
        nchk++;
        if (got !== exp) begin nerr++; $display("FAIL result %h+%h: got %h want %h", a, b, got, exp); end
        for (int i = 0; i < hold; i++) begin
            if (noise) begin
                v8 = 1'b1;
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
            @(negedge clk);
            nchk++;
            if (vo8 !== 1'b1 || rdy8 !== 1'b0 || {co8, s8} !== exp) begin
                nerr++;
                $display("FAIL hold%0d: valid=%b ready=%b out=%h want valid=1 ready=0 out=%h", i, vo8, rdy8, {co8, s8}, exp);
            end
        end
        v8 = 1'b0; r8 = 1'b1;
        @(negedge clk);
        r8 = 1'b0;
        nchk++;
        if (rdy8 !== 1'b1 || vo8 !== 1'b0) begin
            nerr++;
            $display("FAIL release: ready=%b valid=%b want ready=1 valid=0", rdy8, vo8);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        nchk++;
        if ({rdy8, vo8, s8, co8} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            nerr++;
            $display("FAIL reset8: ready=%b valid=%b sum=%h carry=%b want 1 0 00 0", rdy8, vo8, s8, co8);
        end
        nchk++;
        if ({rdy1, vo1, rdy3, vo3, ex_cs[0], ex_cs[1]} !== {4'b1010, 8'h00}) begin
            nerr++;
            $display("FAIL reset_small: r1=%b v1=%b r3=%b v3=%b cs1=%h cs3=%h want 1 0 1 0 0 0", rdy1, vo1, rdy3, vo3, ex_cs[0], ex_cs[1]);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        run8(8'h03, 8'h05, 0, 1'b0);
    endtask

    task automatic test_carry;
        run8(8'hFF, 8'h01, 0, 1'b0);
        run8(8'hFF, 8'hFF, 0, 1'b0);
        run8(8'h80, 8'h80, 0, 1'b0);
    endtask

    task automatic test_backpressure;
        run8(8'h5A, 8'h33, 5, 1'b1);
    endtask

    task automatic test_reset_mid;
        int bad;
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; v8 = 1'b1;
        @(negedge clk);
        v8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        nchk++;
        if (rdy8 !== 1'b1 || vo8 !== 1'b0) begin
            nerr++;
            $display("FAIL reset_mid: ready=%b valid=%b want ready=1 valid=0", rdy8, vo8);
        end
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (vo8 !== 1'b0) bad++;
        end
        nchk++;
        if (bad != 0) begin nerr++; $display("FAIL reset_mid_residue: valid_o high %0d cycles want 0", bad); end
        run8(8'h01, 8'h01, 0, 1'b0);
    endtask

    task automatic test_exhaustive(input int k);
        int w, total, sent, got, budget, bad;
        bit seen;
        logic [3:0] q[$];
        int acc[$];
        logic [3:0] exp;
        w = k ? 3 : 1;
        total = 1 << (2 * w);
        sent = 0; got = 0; seen = 1'b0;
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < total; i++) begin
                    int t;
                    t = 0;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    while (ex_rdy[k] !== 1'b1 && t < 100) begin @(negedge clk); t++; end
                    if (t >= 100) begin nchk++; nerr++; $display("FAIL ex%0d_accept_timeout: item %0d", w, i); end
                    ex_a[k] = 3'(i % (1 << w));
                    ex_b[k] = 3'(i >> w);
                    ex_v[k] = 1'b1;
                    q.push_back(4'(ex_a[k]) + 4'(ex_b[k]));
                    acc.push_back(cyc + 1);
                    sent++;
                    @(negedge clk);
                    ex_v[k] = 1'b0;
                end
            end
            begin
                budget = 0;
                while (got < total && budget < 4000) begin
                    @(negedge clk);
                    budget++;
                    ex_r[k] = 1'b0;
                    if (ex_vo[k] === 1'b1) begin
                        if (q.size() == 0) begin
                            nchk++; nerr++;
                            $display("FAIL ex%0d_spurious: valid_o with no pending operation", w);
                        end else begin
                            if (!seen) begin
                                seen = 1'b1;
                                nchk++;
                                if (cyc - acc[0] != w) begin
                                    nerr++;
                                    $display("FAIL ex%0d_latency: got %0d want %0d", w, cyc - acc[0], w);
                                end
                            end
                            ex_r[k] = 1'($urandom_range(0, 1));
                            if (ex_r[k]) begin
                                exp = q.pop_front();
                                void'(acc.pop_front());
                                nchk++;
                                if (ex_cs[k] !== exp) begin
                                    nerr++;
                                    $display("FAIL ex%0d_result: got %h want %h", w, ex_cs[k], exp);
                                end
                                got++;
                                seen = 1'b0;
                            end
                        end
                    end
                end
                if (budget >= 4000) begin nchk++; nerr++; $display("FAIL ex%0d_timeout: got %0d of %0d", w, got, total); end
            end
        join
        @(negedge clk);
        ex_r[k] = 1'b0;
        nchk++;
        if (sent != total || got != total || q.size() != 0) begin
            nerr++;
            $display("FAIL ex%0d_count: sent %0d got %0d pending %0d want %0d %0d 0", w, sent, got, q.size(), total, total);
        end
        bad = 0;
        repeat (2 * w + 4) begin
            @(negedge clk);
            if (ex_vo[k] !== 1'b0) bad++;
        end
        nchk++;
        if (bad != 0) begin nerr++; $display("FAIL ex%0d_duplicate: valid_o high %0d cycles want 0", w, bad); end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            ex_v[i] = 1'b0;
            ex_r[i] = 1'b0;
            ex_a[i] = '0;
            ex_b[i] = '0;
        end
        test_reset;
        test_basic;
        test_carry;
        test_backpressure;
        test_reset_mid;
        test_exhaustive(0);
        test_exhaustive(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end
endmodule
